// File: rtl/router_input_vc_fifo.sv
// router_input_vc_fifo
// Router input port holding two virtual-channel FIFOs (VC0 = even, VC1 = odd).
// polarity selects which VC is written (polarity) and which is read
// (~polarity), so a single FIFO is never pushed and popped in the same cycle.
// The head flit of the read VC raises exactly one request (pe, cw or ccw).
// A grant counts only when it meets its own request; the flit is then
// forwarded combinationally and popped on that edge. Flits on cw/ccw leave
// with their hop count decremented.
// Optional build macro ROUTER_IN_OCC_EN adds the registered occupancy outputs
// in_occ_even / in_occ_odd.
module router_input_vc_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          polarity,
    input  logic [DW-1:0] ch2in_din,
    input  logic          ch2in_vld,
    output logic          in2ch_rdy,
    output logic          in2cw_req,
    output logic          in2ccw_req,
    output logic          in2pe_req,
    input  logic          cw2in_gnt,
    input  logic          ccw2in_gnt,
    input  logic          pe2in_gnt,
    output logic [DW-1:0] in2out_dout,
`ifdef ROUTER_IN_OCC_EN
    output logic [$clog2(DEPTH+1)-1:0] in_occ_even,
    output logic [$clog2(DEPTH+1)-1:0] in_occ_odd,
`endif
    output logic          in_vc_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic                wr_vc;
    logic                rd_vc;
    logic [1:0]          push_vc;
    logic [1:0]          pop_vc;
    logic [1:0]          full_vc;
    logic [1:0]          empty_vc;
    logic [1:0][DW-1:0]  head_vc;
    logic [1:0][CW-1:0]  count_vc;

    logic                push;
    logic                pop;
    logic [DW-1:0]       head;
    logic [7:0]          head_hop;
    logic                head_dir;
    logic                has_head;
    logic                eff_cw;
    logic                eff_ccw;
    logic                eff_pe;

    assign wr_vc = polarity;
    assign rd_vc = ~polarity;

    // One FIFO per virtual channel; index 0 is the even VC, index 1 the odd VC.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_vc
            logic [DW-1:0] mem_reg [DEPTH];
            logic [PW-1:0] wr_ptr_reg;
            logic [PW-1:0] rd_ptr_reg;
            logic [CW-1:0] count_reg;

            assign push_vc[gi] = push & (wr_vc == 1'(gi));
            assign pop_vc[gi]  = pop  & (rd_vc == 1'(gi));

            // Storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_reg[i] <= '0;
                    end
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push_vc[gi]) begin
                        mem_reg[wr_ptr_reg] <= ch2in_din;
                        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
                    end
                    if (pop_vc[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    // push and pop never target the same VC in one cycle
                    if (push_vc[gi]) begin
                        count_reg <= count_reg + 1'b1;
                    end else if (pop_vc[gi]) begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
            end

            assign head_vc[gi]  = mem_reg[rd_ptr_reg];
            assign count_vc[gi] = count_reg;
        end
    endgenerate

    assign full_vc[0]  = (count_vc[0] == CW'(DEPTH));
    assign full_vc[1]  = (count_vc[1] == CW'(DEPTH));
    assign empty_vc[0] = (count_vc[0] == '0);
    assign empty_vc[1] = (count_vc[1] == '0);

`ifdef ROUTER_IN_OCC_EN
    assign in_occ_even = count_vc[0];
    assign in_occ_odd  = count_vc[1];
`endif

    // Input side: ready tracks the write VC; a flit on the wrong VC is dropped and flagged.
    always_comb begin
        in2ch_rdy = rst | ~full_vc[wr_vc];
        push      = 1'b0;
        in_vc_err = 1'b0;
        if (!rst && ch2in_vld && in2ch_rdy) begin
            if (ch2in_din[DW-1] == polarity) begin
                push = 1'b1;
            end else begin
                in_vc_err = 1'b1;
            end
        end
    end

    assign head     = head_vc[rd_vc];
    assign head_hop = head[DW-9:DW-16];
    assign head_dir = head[DW-2];
    assign has_head = ~rst & ~empty_vc[rd_vc];

    // Route the head flit: hop 0 goes to the local PE, otherwise by direction bit.
    always_comb begin
        in2pe_req  = 1'b0;
        in2cw_req  = 1'b0;
        in2ccw_req = 1'b0;
        if (has_head) begin
            if (head_hop == 8'd0) begin
                in2pe_req = 1'b1;
            end else if (!head_dir) begin
                in2cw_req = 1'b1;
            end else begin
                in2ccw_req = 1'b1;
            end
        end
    end

    assign eff_cw  = in2cw_req  & cw2in_gnt;
    assign eff_ccw = in2ccw_req & ccw2in_gnt;
    assign eff_pe  = in2pe_req  & pe2in_gnt;
    assign pop     = eff_cw | eff_ccw | eff_pe;

    // Output flit: unmodified for the PE, hop decremented when leaving on the ring.
    always_comb begin
        in2out_dout = '0;
        if (eff_pe) begin
            in2out_dout = head;
        end else if (eff_cw || eff_ccw) begin
            in2out_dout              = head;
            in2out_dout[DW-9:DW-16]  = head_hop - 8'd1;
        end
    end

endmodule

// File: doc/router_input_vc_fifo.md
ROUTER_INPUT_VC_FIFO -- requirements
Module: router_input_vc_fifo

Interface
REQ-001 SHALL provide parameter DW, default 64: flit width, legal range 16 or more.
REQ-002 SHALL provide parameter DEPTH, default 4: entries per VC FIFO, a power of 2, minimum 2.
REQ-003 SHALL provide port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL provide port polarity, input, 1 bit: selects the write VC and the read VC.
REQ-006 SHALL provide port ch2in_din, input, DW bits: incoming flit.
REQ-007 SHALL provide port ch2in_vld, input, 1 bit: incoming flit valid.
REQ-008 SHALL provide port in2ch_rdy, output, 1 bit: ready to accept a flit.
REQ-009 SHALL provide port in2cw_req, in2ccw_req and in2pe_req, outputs, 1 bit each: head-flit requests to the cw, ccw and local-PE outputs.
REQ-010 SHALL provide port cw2in_gnt, ccw2in_gnt and pe2in_gnt, inputs, 1 bit each: grants for those requests.
REQ-011 SHALL provide port in2out_dout, output, DW bits: granted flit.
REQ-012 SHALL provide port in_vc_err, output, 1 bit: wrong-VC flit dropped this cycle.

Function
REQ-013 SHALL use this flit format: bit DW-1 = VC (0 even, 1 odd); bit DW-2 = direction (0 cw, 1 ccw); bits [DW-9:DW-16] = 8-bit hop count.
REQ-014 SHALL hold two independent FIFOs, VC0 and VC1, each DEPTH entries deep, each with its own read pointer, write pointer and occupancy count.
REQ-015 SHALL make the write VC equal to polarity and the read VC equal to ~polarity, so a single FIFO is never pushed and popped in the same cycle.
REQ-016 SHALL drive in2ch_rdy = ~full(write VC), combinationally.
REQ-017 SHALL accept a flit when ch2in_vld and in2ch_rdy are both high and din[DW-1] == polarity, pushing it into the write VC on that edge.
REQ-018 SHALL drop a flit when ch2in_vld and in2ch_rdy are both high and din[DW-1] != polarity: no write, and in_vc_err = 1 combinationally in that cycle.
REQ-019 SHALL drive in_vc_err = 0 whenever no flit is dropped.
REQ-020 SHALL not write anything while ch2in_vld = 1 and the write VC is full; the sender holds the flit.
REQ-021 SHALL raise requests only when the read VC is non-empty, based on its head flit H:
- hop(H) == 0: in2pe_req = 1.
- otherwise, dir = 0: in2cw_req = 1.
- otherwise, dir = 1: in2ccw_req = 1.
REQ-022 SHALL keep at most one request high at any time; all requests are 0 while the read VC is empty.
REQ-023 SHALL treat a grant as effective only when it arrives together with its own matching request; all other grants are ignored.
REQ-024 SHALL pop the read VC on the clock edge that ends an effective-grant cycle.
REQ-025 SHALL drive in2out_dout combinationally in an effective-grant cycle:
- cw or ccw grant: H with its hop field decremented by 1 (8-bit, no wrap is possible because hop != 0).
- pe grant: H unmodified.
REQ-026 SHALL drive in2out_dout = 0 in all cycles without an effective grant.
REQ-027 SHALL wrap FIFO pointers modulo DEPTH and keep occupancy within 0..DEPTH.
REQ-028 SHALL switch write and read VC on the very next cycle after polarity toggles; flits stored in either VC are retained across the toggle.
REQ-029 SHALL add zero cycles of latency through the FIFO beyond the storage edge: a flit written at edge N can be requested in cycle N+1 once polarity selects it for reading.

Reset
REQ-030 SHALL, on rst = 1 at a clock edge, clear both FIFOs to empty, zero all pointers and counts, and write all storage to 0.
REQ-031 SHALL hold these output values while rst is held: in2ch_rdy = 1, all requests = 0, in2out_dout = 0, in_vc_err = 0.
REQ-032 SHALL give rst priority over any simultaneous push or pop; a flit in flight at reset is lost.

Configuration
REQ-033 SHALL, when macro ROUTER_IN_OCC_EN is defined, add outputs in_occ_even and in_occ_odd, each $clog2(DEPTH+1) bits, giving the registered occupancy of VC0 and VC1; both reset to 0.
REQ-034 SHALL, when ROUTER_IN_OCC_EN is not defined, omit those ports entirely and leave all other behaviour identical.

Verification
REQ-035 SHALL cover single flit, DEPTH = 4: polarity = 0, push din = {VC0, dir 0, hop 3}, then polarity = 1 and cw grant -> in2cw_req = 1; dout hop = 2; VC0 empty the next cycle.
REQ-036 SHALL cover fill to full: polarity = 1, push 4 VC1 flits -> in2ch_rdy = 0 after the 4th; a 5th flit held with vld stays unwritten; then polarity = 0 and 1 effective grant -> rdy = 1 once polarity returns to 1.
REQ-037 SHALL cover hop-0 flit: head with hop = 0 -> in2pe_req = 1 and cw/ccw requests = 0; with pe grant, dout equals the head exactly.
REQ-038 SHALL cover wrong VC: polarity = 0, vld = 1, din[DW-1] = 1 -> in_vc_err = 1 and VC0 occupancy unchanged.
REQ-039 SHALL cover non-matching grant: head requests ccw, bench drives cw grant -> no pop, dout = 0.
REQ-040 SHALL cover reset mid-operation: rst = 1 with 3 flits stored -> next cycle all requests = 0, rdy = 1 and, when ROUTER_IN_OCC_EN is defined, occupancy outputs = 0.
